seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display with decimal points.
- Successor to the single-digit BCD segment decoder. Adds a digit count parameter, hex glyphs A-F, per-digit decimal point and blanking, optional leading-zero suppression, and a dead-time guard between digits.
- Sits between the datapath (counters, measurement results) and the board display pins.
- Takes a parallel nibble bus and produces registered segment and digit-select outputs.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clk cycles each digit is lit (DISPLAY phase); minimum 2.
- GUARD_CYC, 2: clk cycles with all digits off between digits (GUARD phase); 0 disables the guard phase.
- HEX_EN, 1: 1 = nibbles 10-15 show A,b,C,d,E,F; 0 = nibbles 10-15 are blanked.
- LZ_SUPPRESS, 0: 1 = leading zeros blanked. The lowest digit (digit 0) is never suppressed.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: 1 = scanning; 0 = display dark.
- load, in, 1: one-cycle strobe that captures the three value inputs below into the staging registers.
- digits_i, in, 4*NUM_DIGITS: packed nibbles; digit k = bits [4k+3:4k]; digit 0 is the rightmost.
- dp_i, in, NUM_DIGITS: 1 = decimal point lit for digit k.
- blank_i, in, NUM_DIGITS: 1 = digit k forced dark, including its dp.
- seg_o, out, 8: active-low segments, bit order {dp,g,f,e,d,c,b,a}.
- sel_o, out, NUM_DIGITS: active-low digit enables; at most one bit low at any time.
- frame_done, out, 1: one-cycle pulse at the end of the last digit's DISPLAY phase.

Behaviour:
- Reset (async, rst_n low):
  - seg_o = 8'hFF; sel_o = all ones; frame_done = 0.
  - Staging and active registers cleared (all digits 0, dp 0, blank all 1).
  - State = GUARD with the guard counter at 0; digit index = 0.
- Registers and update timing:
  - load captures the value inputs into the staging registers.
  - Staging copies into the active registers only at a frame boundary (the cycle frame_done is high), or immediately when en = 0. No tearing inside a frame.
  - load asserted on the same cycle as frame_done: the old staging value is copied to active and the new value goes to staging.
- Decode (internal active-high, output inverted):
  - Glyphs 0-9 are 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Glyphs A-F are 77,7C,39,5E,79,71.
  - dp sets bit7 internally.
  - Example: nibble 0 with dp lit gives seg_o = 8'h40; without dp gives 8'hC0.
- Leading-zero suppression: digit k is blanked when LZ_SUPPRESS = 1, nibbles NUM_DIGITS-1 down to k are all 0, and k > 0. The dp of a suppressed digit is still shown if dp_i is set.
- State machine (active only while en = 1):
  - GUARD: sel_o all ones, seg_o = FF. After GUARD_CYC cycles go to DISPLAY. When GUARD_CYC = 0 the state is skipped.
  - DISPLAY: sel_o[idx] = 0, seg_o = decoded glyph of digit idx. After SCAN_DIV cycles advance idx, wrapping NUM_DIGITS-1 to 0, and go to GUARD.
  - frame_done pulses on the final DISPLAY cycle of idx = NUM_DIGITS-1.
  - seg_o and sel_o change on the same clock edge, so there is no one-cycle mismatch.
- en handling:
  - en deasserted mid-digit: next cycle outputs go dark, idx returns to 0, state returns to GUARD with the counter cleared.
  - en reasserted: scanning resumes from digit 0 after the guard phase.
- NUM_DIGITS = 1: idx is constant 0 and frame_done pulses once per DISPLAY phase.
- Counter width is clog2(max(SCAN_DIV, GUARD_CYC, 1)) + 1.

Decomposition:
- Shared package seg_pkg holds:
  - 16-entry glyph constant array;
  - SEG_BLANK = 8'h00 (active-high);
  - bit index constants for segments a..g and dp.
- One sub-module: seg_glyph_dec. Combinational; inputs nibble, dp, blank, hex_en; output 8-bit active-high pattern.
- The top inverts the pattern and registers it into seg_o.

Test Plan:
1. Reset check: assert rst_n low mid-DISPLAY -> seg_o = FF and sel_o = F within the same cycle, frame_done = 0.
2. Value 4'h3210 with dp = 0001, NUM_DIGITS = 4, SCAN_DIV = 4, GUARD_CYC = 1:
   - digit 0 shows seg_o = 40, digit 1 shows F9, digit 2 shows A4, digit 3 shows B0;
   - sel_o sequence E, D, B, 7 with F between digits;
   - frame_done period is 20 cycles.
3. Value 4'hAbF0 with HEX_EN = 1 -> segments 88, 83, 8E, C0 (digit 3 down to digit 0). With HEX_EN = 0, digits 3..1 show FF.
4. LZ_SUPPRESS = 1 and value 0x0070 -> digits 3 and 2 show seg_o = FF, digit 1 shows F8, digit 0 shows C0.
5. load of a new value mid-frame -> old value persists until frame_done; the new value appears on digit 0 of the next frame.
6. en dropped during digit 2 -> dark on the next cycle. On re-enable, the first lit digit is 0 after GUARD_CYC cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, segment bit indices
// and scan FSM state type.
package seg_pkg;

  typedef enum logic [0:0] {StGuard, StDisplay} scan_state_e;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high {dp,g,f,e,d,c,b,a}; dp is left clear and merged in by the decoder.
  localparam logic [7:0] GLYPH_TAB [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic int unsigned cnt_span(input int unsigned scan_div,
                                           input int unsigned guard_cyc);
    int unsigned m;
    m = 1;
    if (scan_div > m) m = scan_div;
    if (guard_cyc > m) m = guard_cyc;
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Value bus into the scan driver and the display-pin outputs coming back from it.
interface seg_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      en;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_i;
  logic [NUM_DIGITS-1:0]     dp_i;
  logic [NUM_DIGITS-1:0]     blank_i;
  logic [7:0]                seg_o;
  logic [NUM_DIGITS-1:0]     sel_o;
  logic                      frame_done;

  modport master (
    output en, load, digits_i, dp_i, blank_i,
    input  seg_o, sel_o, frame_done
  );

  modport slave (
    input  en, load, digits_i, dp_i, blank_i,
    output seg_o, sel_o, frame_done
  );
endinterface

// File: rtl/seg_glyph_dec.sv
// Nibble to active-high segment pattern, with decimal point and forced blanking.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  input  logic       hex_en_i,
  output logic [7:0] pattern_o
);

  always_comb begin
    pattern_o = SEG_BLANK;
    if (!blank_i) begin
      if (hex_en_i || (nibble_i < 4'd10)) begin
        pattern_o = GLYPH_TAB[nibble_i];
      end
      pattern_o[SEG_DP] = dp_i;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit common-anode seven-segment driver with frame-synchronous
// value updates, guard time between digits and optional leading-zero suppression.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned GUARD_CYC   = 2,
  parameter bit          HEX_EN      = 1'b1,
  parameter bit          LZ_SUPPRESS = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_mux_if.slave bus
);

  localparam int unsigned CntW = $clog2(cnt_span(SCAN_DIV, GUARD_CYC)) + 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DigW = 4 * NUM_DIGITS;

  logic [DigW-1:0]       stage_dig_q, act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] stage_dp_q, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] stage_blank_q, act_blank_q, act_blank_d;

  scan_state_e           state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q, idx_nxt;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  frame_done_q;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [7:0]            glyph [NUM_DIGITS];

  // Active values only move at a frame boundary (or while dark) so a frame never tears.
  always_comb begin
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (frame_done_q || !bus.en) begin
      act_dig_d   = stage_dig_q;
      act_dp_d    = stage_dp_q;
      act_blank_d = stage_blank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_dig_q   <= '0;
      stage_dp_q    <= '0;
      stage_blank_q <= '1;
      act_dig_q     <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
    end else begin
      if (bus.load) begin
        stage_dig_q   <= bus.digits_i;
        stage_dp_q    <= bus.dp_i;
        stage_blank_q <= bus.blank_i;
      end
      act_dig_q   <= act_dig_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
    end
  end

  // Scan from the top digit down; a digit is suppressed while everything above it is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run   = zero_run & (act_dig_d[4*k +: 4] == 4'h0);
      lz_mask[k] = LZ_SUPPRESS && (k != 0) && zero_run;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    logic [7:0] pat;
    seg_glyph_dec u_dec (
      .nibble_i  (act_dig_d[4*k +: 4]),
      .dp_i      (act_dp_d[k]),
      .blank_i   (act_blank_d[k]),
      .hex_en_i  (HEX_EN),
      .pattern_o (pat)
    );
    assign glyph[k] = lz_mask[k] ? {pat[SEG_DP], 7'b0} : pat;
  end

  always_comb begin
    idx_nxt = idx_q + 1'b1;
    if (idx_q == IdxW'(NUM_DIGITS - 1)) idx_nxt = '0;
  end

  // Outputs are loaded on the same edge as the state they belong to, so seg and sel agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StGuard;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= 8'hFF;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
    end else if (!bus.en) begin
      state_q      <= StGuard;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= 8'hFF;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StGuard: begin
          if (GUARD_CYC == 0 || cnt_q == CntW'(GUARD_CYC - 1)) begin
            state_q <= StDisplay;
            cnt_q   <= '0;
            seg_q   <= ~glyph[idx_q];
            sel_q   <= ~(NUM_DIGITS'(1) << idx_q);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDisplay: begin
          if (cnt_q == CntW'(SCAN_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= idx_nxt;
            if (GUARD_CYC == 0) begin
              seg_q <= ~glyph[idx_nxt];
              sel_q <= ~(NUM_DIGITS'(1) << idx_nxt);
            end else begin
              state_q <= StGuard;
              seg_q   <= 8'hFF;
              sel_q   <= '1;
            end
          end else begin
            cnt_q        <= cnt_q + 1'b1;
            frame_done_q <= (idx_q == IdxW'(NUM_DIGITS - 1)) &&
                            (cnt_q == CntW'(SCAN_DIV - 2));
          end
        end
        default: state_q <= StGuard;
      endcase
    end
  end

  assign bus.seg_o      = seg_q;
  assign bus.sel_o      = sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux: three configurations driven in parallel and checked
// against a timing/value model derived from enabled-edge counts.
module tb_seg_scan_mux;

  localparam int unsigned N = 4;
  localparam int unsigned S = 4;
  localparam int unsigned G = 1;
  localparam int unsigned P = G + S;

  localparam logic [7:0] GLYPHS [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          en_r, load_r;
  logic [15:0]   dig_r;
  logic [N-1:0]  dp_r, blank_r;

  seg_scan_mux_if #(.NUM_DIGITS(N)) bus_hex ();
  seg_scan_mux_if #(.NUM_DIGITS(N)) bus_nohex ();
  seg_scan_mux_if #(.NUM_DIGITS(N)) bus_lz ();

  assign bus_hex.en         = en_r;
  assign bus_hex.load       = load_r;
  assign bus_hex.digits_i   = dig_r;
  assign bus_hex.dp_i       = dp_r;
  assign bus_hex.blank_i    = blank_r;
  assign bus_nohex.en       = en_r;
  assign bus_nohex.load     = load_r;
  assign bus_nohex.digits_i = dig_r;
  assign bus_nohex.dp_i     = dp_r;
  assign bus_nohex.blank_i  = blank_r;
  assign bus_lz.en          = en_r;
  assign bus_lz.load        = load_r;
  assign bus_lz.digits_i    = dig_r;
  assign bus_lz.dp_i        = dp_r;
  assign bus_lz.blank_i     = blank_r;

  seg_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .GUARD_CYC(G), .HEX_EN(1'b1), .LZ_SUPPRESS(1'b0)
  ) u_dut_hex (.clk(clk), .rst_n(rst_n), .bus(bus_hex));

  seg_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .GUARD_CYC(G), .HEX_EN(1'b0), .LZ_SUPPRESS(1'b0)
  ) u_dut_nohex (.clk(clk), .rst_n(rst_n), .bus(bus_nohex));

  seg_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .GUARD_CYC(G), .HEX_EN(1'b1), .LZ_SUPPRESS(1'b1)
  ) u_dut_lz (.clk(clk), .rst_n(rst_n), .bus(bus_lz));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: staged/shown values and number of enabled edges since dark.
  logic [15:0]  stg_dig, act_dig;
  logic [N-1:0] stg_dp, act_dp, stg_blank, act_blank;
  int           n_edges;
  logic         fd_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    stg_dig   = '0;
    act_dig   = '0;
    stg_dp    = '0;
    act_dp    = '0;
    stg_blank = '1;
    act_blank = '1;
    n_edges   = 0;
    fd_exp    = 1'b0;
  endtask

  function automatic bit lit(input int n);
    return (n % int'(P)) >= int'(G);
  endfunction

  function automatic int digit_of(input int n);
    return (n / int'(P)) % int'(N);
  endfunction

  function automatic logic [7:0] exp_seg(input bit hex, input bit lz, input int n);
    int         d;
    logic [3:0] nib;
    logic [7:0] pat;
    if (!lit(n)) return 8'hFF;
    d = digit_of(n);
    if (act_blank[d]) return 8'hFF;
    nib = act_dig[4*d +: 4];
    pat = GLYPHS[nib];
    if (!hex && nib >= 4'd10) pat = 8'h00;
    if (lz && d > 0 && (act_dig >> (4*d)) == 16'h0) pat = 8'h00;
    pat[7] = act_dp[d];
    return ~pat;
  endfunction

  function automatic logic [N-1:0] exp_sel(input int n);
    if (!lit(n)) return '1;
    return ~(N'(1) << digit_of(n));
  endfunction

  function automatic logic exp_fd(input int n);
    return lit(n) && (n % int'(P)) == int'(P) - 1 && digit_of(n) == int'(N) - 1;
  endfunction

  task automatic check_all();
    check("seg_hex",   {24'h0, bus_hex.seg_o},   {24'h0, exp_seg(1'b1, 1'b0, n_edges)});
    check("seg_nohex", {24'h0, bus_nohex.seg_o}, {24'h0, exp_seg(1'b0, 1'b0, n_edges)});
    check("seg_lz",    {24'h0, bus_lz.seg_o},    {24'h0, exp_seg(1'b1, 1'b1, n_edges)});
    check("sel_hex",   {28'h0, bus_hex.sel_o},   {28'h0, exp_sel(n_edges)});
    check("sel_lz",    {28'h0, bus_lz.sel_o},    {28'h0, exp_sel(n_edges)});
    check("frame_done", {31'h0, bus_hex.frame_done}, {31'h0, fd_exp});
  endtask

  task automatic cycle(input logic en_v, input logic ld, input logic [15:0] dig,
                       input logic [N-1:0] dp, input logic [N-1:0] blk);
    en_r    = en_v;
    load_r  = ld;
    dig_r   = dig;
    dp_r    = dp;
    blank_r = blk;
    @(posedge clk);
    if (fd_exp || !en_v) begin
      act_dig   = stg_dig;
      act_dp    = stg_dp;
      act_blank = stg_blank;
    end
    if (ld) begin
      stg_dig   = dig;
      stg_dp    = dp;
      stg_blank = blk;
    end
    n_edges = en_v ? n_edges + 1 : 0;
    fd_exp  = exp_fd(n_edges);
    #1;
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(1'b1, 1'b0, dig_r, dp_r, blank_r);
  endtask

  initial begin
    en_r    = 1'b0;
    load_r  = 1'b0;
    dig_r   = '0;
    dp_r    = '0;
    blank_r = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset_seg", {24'h0, bus_hex.seg_o}, 32'hFF);
    check("reset_sel", {28'h0, bus_hex.sel_o}, 32'hF);
    check("reset_fd",  {31'h0, bus_hex.frame_done}, 32'h0);
    rst_n = 1'b1;

    // 0x3210 with dp on digit 0, loaded while dark so it is shown from the first frame.
    cycle(1'b0, 1'b1, 16'h3210, 4'b0001, 4'b0000);
    cycle(1'b0, 1'b0, 16'h3210, 4'b0001, 4'b0000);
    run(2 * P * N);

    // New value mid-frame: must wait for the frame boundary.
    run(7);
    cycle(1'b1, 1'b1, 16'hABF0, 4'b0000, 4'b0000);
    run(2 * P * N);

    cycle(1'b1, 1'b1, 16'h0070, 4'b0000, 4'b0000);
    run(2 * P * N);

    // Drop en while digit 2 is lit, then resume.
    for (int i = 0; i < 100 && exp_sel(n_edges) != 4'hB; i++) run(1);
    check("reach_digit2", {28'h0, exp_sel(n_edges)}, 32'hB);
    run(1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, dig_r, dp_r, blank_r);
    run(3 * P);

    // Asynchronous reset while a digit is lit.
    for (int i = 0; i < 100 && !lit(n_edges); i++) run(1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg", {24'h0, bus_hex.seg_o}, 32'hFF);
    check("async_rst_sel", {28'h0, bus_hex.sel_o}, 32'hF);
    check("async_rst_fd",  {31'h0, bus_hex.frame_done}, 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run(2 * P * N);

    for (int i = 0; i < 3000; i++) begin
      logic        en_v, ld;
      logic [15:0] dig;
      en_v = ($urandom_range(0, 99) >= 2);
      ld   = ($urandom_range(0, 7) == 0);
      dig  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if (ld) cycle(en_v, 1'b1, dig, N'($urandom), N'($urandom & $urandom & $urandom));
      else    cycle(en_v, 1'b0, dig_r, dp_r, blank_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
